// File: rtl/rs_fp_pkg.sv
// Shared definitions for the FP reservation station: widths, packed entry layout and CDB bundle.
// The field order of fp_entry_t matches the 114-bit entry: rd at bit 0, zero padding at [113:85].
package rs_fp_pkg;

  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = 114;
  localparam int ZERO_W  = 29;

  typedef struct packed {
    logic [ZERO_W-1:0] zero;        // [113:85]
    logic [TAG_W-1:0]  rs2_tag;     // [84:81]
    logic [4:0]        aluop;       // [80:76]
    logic [TAG_W-1:0]  rs1_tag;     // [75:72]
    logic              fpregwrite;  // [71]
    logic [DATA_W-1:0] rs2_val;     // [70:39]
    logic              rs2_rdy;     // [38]
    logic [DATA_W-1:0] rs1_val;     // [37:6]
    logic              rs1_rdy;     // [5]
    logic [4:0]        rd;          // [4:0]
  } fp_entry_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

  function automatic logic [1:0] count_free(input logic [1:0] valid);
    return {1'b0, ~valid[0]} + {1'b0, ~valid[1]};
  endfunction

endpackage

// File: rtl/rs_fp_wakeup.sv
// Operand capture for one entry: a not-ready operand whose tag matches a CDB takes its data.
// Purely combinational; CDB0 wins when both buses carry the operand's tag.
module rs_fp_wakeup
  import rs_fp_pkg::*;
(
  input  logic      en,
  input  fp_entry_t base,
  input  cdb_t      cdb0,
  input  cdb_t      cdb1,
  output fp_entry_t result
);

  always_comb begin
    result = base;
    if (en && !base.rs1_rdy) begin
      if (cdb0.valid && cdb0.tag == base.rs1_tag) begin
        result.rs1_rdy = 1'b1;
        result.rs1_val = cdb0.data;
      end else if (cdb1.valid && cdb1.tag == base.rs1_tag) begin
        result.rs1_rdy = 1'b1;
        result.rs1_val = cdb1.data;
      end
    end
    if (en && !base.rs2_rdy) begin
      if (cdb0.valid && cdb0.tag == base.rs2_tag) begin
        result.rs2_rdy = 1'b1;
        result.rs2_val = cdb0.data;
      end else if (cdb1.valid && cdb1.tag == base.rs2_tag) begin
        result.rs2_rdy = 1'b1;
        result.rs2_val = cdb1.data;
      end
    end
  end

endmodule

// File: rtl/rs_fp.sv
// Two-entry FP reservation station: dispatch/wakeup visible one cycle later; requests beyond free slots are dropped.
// Define RS_FP_BYPASS_EN to let a dispatched operand capture a CDB broadcast from its own dispatch cycle.
module rs_fp
  import rs_fp_pkg::*;
#(
  parameter int TAG_W   = rs_fp_pkg::TAG_W,
  parameter int ENTRY_W = rs_fp_pkg::ENTRY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               disp0_valid,
  input  logic [ENTRY_W-1:0] disp0_entry,
  input  logic [TAG_W-1:0]   disp0_rob,
  input  logic               disp1_valid,
  input  logic [ENTRY_W-1:0] disp1_entry,
  input  logic [TAG_W-1:0]   disp1_rob,
  input  logic               cdb0_valid,
  input  logic [TAG_W-1:0]   cdb0_tag,
  input  logic [31:0]        cdb0_data,
  input  logic               cdb1_valid,
  input  logic [TAG_W-1:0]   cdb1_tag,
  input  logic [31:0]        cdb1_data,
  input  logic               fp_0_issue,
  input  logic               fp_1_issue,
  output logic [ENTRY_W-1:0] rs_fp_0,
  output logic [ENTRY_W-1:0] rs_fp_1,
  output logic [TAG_W-1:0]   rs_fp_0_entry_num,
  output logic [TAG_W-1:0]   rs_fp_1_entry_num,
  output logic               selector,
  output logic [1:0]         rs_fp_free
);

  logic [1:0]         valid_q, valid_d;
  logic [ENTRY_W-1:0] entry_q [2];
  logic [TAG_W-1:0]   rob_q [2];
  logic               sel_q, sel_d;

  logic [1:0] free, wr, src, wake_en, issue;
  fp_entry_t  base [2];
  fp_entry_t  woken [2];
  cdb_t       cdb0, cdb1;

  assign cdb0  = '{valid: cdb0_valid, tag: cdb0_tag, data: cdb0_data};
  assign cdb1  = '{valid: cdb1_valid, tag: cdb1_tag, data: cdb1_data};
  assign issue = {fp_1_issue, fp_0_issue};
  assign free  = ~valid_q;

  // Allocation looks at registered occupancy only, so a slot issued this cycle is not reused until next cycle.
  always_comb begin
    wr  = 2'b00;
    src = 2'b00;
    if (disp0_valid && disp1_valid) begin
      if (free == 2'b11) begin
        wr  = 2'b11;
        src = 2'b10;
      end else if (free[0]) begin
        wr[0] = 1'b1;
      end else if (free[1]) begin
        wr[1] = 1'b1;
      end
    end else if (disp0_valid || disp1_valid) begin
      if (free[0]) begin
        wr[0]  = 1'b1;
        src[0] = disp1_valid;
      end else if (free[1]) begin
        wr[1]  = 1'b1;
        src[1] = disp1_valid;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      base[i] = fp_entry_t'(entry_q[i]);
      if (wr[i]) begin
        base[i]      = fp_entry_t'(src[i] ? disp1_entry : disp0_entry);
        base[i].zero = '0;
      end
    end
  end

  // Wakeup applies to held entries that are not leaving this cycle; fresh dispatches only with bypass.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
`ifdef RS_FP_BYPASS_EN
      wake_en[i] = wr[i] | (valid_q[i] & ~issue[i]);
`else
      wake_en[i] = valid_q[i] & ~issue[i];
`endif
    end
  end

  rs_fp_wakeup u_wake0 (
    .en     (wake_en[0]),
    .base   (base[0]),
    .cdb0   (cdb0),
    .cdb1   (cdb1),
    .result (woken[0])
  );

  rs_fp_wakeup u_wake1 (
    .en     (wake_en[1]),
    .base   (base[1]),
    .cdb0   (cdb0),
    .cdb1   (cdb1),
    .result (woken[1])
  );

  assign valid_d = wr | (valid_q & ~issue);

  always_comb begin
    sel_d = sel_q;
    if (valid_d == 2'b00) begin
      sel_d = 1'b0;
    end else if (wr == 2'b11) begin
      sel_d = 1'b1;
    end else if (wr[0]) begin
      sel_d = 1'b0;
    end else if (wr[1]) begin
      sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 2'b00;
      sel_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
        rob_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
      for (int i = 0; i < 2; i++) begin
        if (wr[i] || wake_en[i]) begin
          entry_q[i] <= woken[i];
        end
        if (wr[i]) begin
          rob_q[i] <= src[i] ? disp1_rob : disp0_rob;
        end
      end
    end
  end

  assign rs_fp_0           = valid_q[0] ? entry_q[0] : '0;
  assign rs_fp_1           = valid_q[1] ? entry_q[1] : '0;
  assign rs_fp_0_entry_num = rob_q[0];
  assign rs_fp_1_entry_num = rob_q[1];
  assign selector          = sel_q;
  assign rs_fp_free        = count_free(valid_q);

endmodule

// File: tb/tb_rs_fp.sv
// Bench for rs_fp: directed scenarios then random traffic, checked by a scoreboard fed from a reference model.
module tb_rs_fp;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         disp0_valid, disp1_valid;
  logic [113:0] disp0_entry, disp1_entry;
  logic [3:0]   disp0_rob, disp1_rob;
  logic         cdb0_valid, cdb1_valid;
  logic [3:0]   cdb0_tag, cdb1_tag;
  logic [31:0]  cdb0_data, cdb1_data;
  logic         fp_0_issue, fp_1_issue;
  logic [113:0] rs_fp_0, rs_fp_1;
  logic [3:0]   rs_fp_0_entry_num, rs_fp_1_entry_num;
  logic         selector;
  logic [1:0]   rs_fp_free;

  always #5 clk = ~clk;

  rs_fp dut (
    .clk(clk), .rst_n(rst_n),
    .disp0_valid(disp0_valid), .disp0_entry(disp0_entry), .disp0_rob(disp0_rob),
    .disp1_valid(disp1_valid), .disp1_entry(disp1_entry), .disp1_rob(disp1_rob),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .fp_0_issue(fp_0_issue), .fp_1_issue(fp_1_issue),
    .rs_fp_0(rs_fp_0), .rs_fp_1(rs_fp_1),
    .rs_fp_0_entry_num(rs_fp_0_entry_num), .rs_fp_1_entry_num(rs_fp_1_entry_num),
    .selector(selector), .rs_fp_free(rs_fp_free)
  );

`ifdef RS_FP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic rstn;
    logic d0; logic [113:0] e0; logic [3:0] r0;
    logic d1; logic [113:0] e1; logic [3:0] r1;
    logic c0v; logic [3:0] c0t; logic [31:0] c0d;
    logic c1v; logic [3:0] c1t; logic [31:0] c1d;
    logic i0; logic i1;
  } stim_t;

  typedef struct {
    logic [113:0] rs0, rs1;
    logic [3:0]   en0, en1;
    logic         v0, v1, sel;
    logic [1:0]   free;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: which slots hold an instruction, what it holds, and which slot is newest.
  logic         m_v [2];
  logic [113:0] m_e [2];
  logic [3:0]   m_r [2];
  logic         m_sel;

  function automatic logic [113:0] wake(input logic [113:0] e, input stim_t s);
    logic [113:0] r;
    r = e;
    if (!e[5]) begin
      if (s.c0v && s.c0t == e[75:72]) begin r[5] = 1'b1; r[37:6] = s.c0d; end
      else if (s.c1v && s.c1t == e[75:72]) begin r[5] = 1'b1; r[37:6] = s.c1d; end
    end
    if (!e[38]) begin
      if (s.c0v && s.c0t == e[84:81]) begin r[38] = 1'b1; r[70:39] = s.c0d; end
      else if (s.c1v && s.c1t == e[84:81]) begin r[38] = 1'b1; r[70:39] = s.c1d; end
    end
    return r;
  endfunction

  function automatic int model_free();
    return (m_v[0] ? 0 : 1) + (m_v[1] ? 0 : 1);
  endfunction

  task automatic model_step(input stim_t s);
    int fr[$];
    int rq[$];
    int n;
    logic [113:0] e;
    exp_t x;
    if (!s.rstn) begin
      for (int i = 0; i < 2; i++) begin m_v[i] = 1'b0; m_e[i] = '0; m_r[i] = '0; end
      m_sel = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) if (!m_v[i]) fr.push_back(i);
      if (s.d0) rq.push_back(0);
      if (s.d1) rq.push_back(1);
      n = (rq.size() < fr.size()) ? rq.size() : fr.size();
      for (int i = 0; i < 2; i++) begin
        if (m_v[i]) begin
          if ((i == 0) ? s.i0 : s.i1) m_v[i] = 1'b0;
          else m_e[i] = wake(m_e[i], s);
        end
      end
      for (int k = 0; k < n; k++) begin
        e = (rq[k] == 1) ? s.e1 : s.e0;
        e[113:85] = '0;
        if (BYPASS) e = wake(e, s);
        m_e[fr[k]] = e;
        m_r[fr[k]] = (rq[k] == 1) ? s.r1 : s.r0;
        m_v[fr[k]] = 1'b1;
      end
      if (!m_v[0] && !m_v[1]) m_sel = 1'b0;
      else if (n == 2) m_sel = 1'b1;
      else if (n == 1) m_sel = fr[0][0];
    end
    x.rs0  = m_v[0] ? m_e[0] : '0;
    x.rs1  = m_v[1] ? m_e[1] : '0;
    x.en0  = m_r[0];
    x.en1  = m_r[1];
    x.v0   = m_v[0];
    x.v1   = m_v[1];
    x.sel  = m_sel;
    x.free = 2'(model_free());
    sb.push_back(x);
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    rst_n = s.rstn;
    disp0_valid = s.d0; disp0_entry = s.e0; disp0_rob = s.r0;
    disp1_valid = s.d1; disp1_entry = s.e1; disp1_rob = s.r1;
    cdb0_valid = s.c0v; cdb0_tag = s.c0t; cdb0_data = s.c0d;
    cdb1_valid = s.c1v; cdb1_tag = s.c1t; cdb1_data = s.c1d;
    fp_0_issue = s.i0; fp_1_issue = s.i1;
    model_step(s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rstn = 1'b1;
    s.d0 = 1'b0; s.e0 = '0; s.r0 = '0;
    s.d1 = 1'b0; s.e1 = '0; s.r1 = '0;
    s.c0v = 1'b0; s.c0t = '0; s.c0d = '0;
    s.c1v = 1'b0; s.c1t = '0; s.c1d = '0;
    s.i0 = 1'b0; s.i1 = 1'b0;
    return s;
  endfunction

  function automatic logic [113:0] rand_entry();
    logic [113:0] e;
    e = '0;
    e[4:0]   = 5'($urandom);
    e[5]     = 1'($urandom);
    e[37:6]  = $urandom;
    e[38]    = 1'($urandom);
    e[70:39] = $urandom;
    e[71]    = 1'($urandom);
    e[75:72] = 4'($urandom_range(0, 5));
    e[80:76] = 5'($urandom);
    e[84:81] = 4'($urandom_range(0, 5));
    return e;
  endfunction

  task automatic chk(input string name, input logic [113:0] act, input logic [113:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: the DUT presents its state every cycle; compare it after each edge against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("rs_fp_0", rs_fp_0, x.rs0);
        chk("rs_fp_1", rs_fp_1, x.rs1);
        chk("selector", 114'(selector), 114'(x.sel));
        chk("rs_fp_free", 114'(rs_fp_free), 114'(x.free));
        if (x.v0) chk("entry_num0", 114'(rs_fp_0_entry_num), 114'(x.en0));
        if (x.v1) chk("entry_num1", 114'(rs_fp_1_entry_num), 114'(x.en1));
      end
    end
  end

  initial begin
    stim_t s;
    int f;
    rst_n = 1'b0;
    disp0_valid = 1'b0; disp0_entry = '0; disp0_rob = '0;
    disp1_valid = 1'b0; disp1_entry = '0; disp1_rob = '0;
    cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
    cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
    fp_0_issue = 1'b0; fp_1_issue = 1'b0;
    for (int i = 0; i < 2; i++) begin m_v[i] = 1'b0; m_e[i] = '0; m_r[i] = '0; end
    m_sel = 1'b0;

    // Reset held two cycles with a dispatch request present.
    s = idle(); s.rstn = 1'b0; s.d0 = 1'b1; s.e0 = rand_entry(); s.r0 = 4'd2;
    drive(s); drive(s);
    drive(idle());

    // Dual dispatch, both operands ready.
    s = idle();
    s.d0 = 1'b1; s.e0 = rand_entry(); s.e0[5] = 1'b1; s.e0[38] = 1'b1; s.r0 = 4'd3;
    s.d1 = 1'b1; s.e1 = rand_entry(); s.e1[5] = 1'b1; s.e1[38] = 1'b1; s.r1 = 4'd5;
    drive(s);
    s = idle(); s.i0 = 1'b1; s.i1 = 1'b1; drive(s);

    // Wakeup of rs1 from CDB1.
    s = idle(); s.d0 = 1'b1; s.e0 = rand_entry(); s.e0[5] = 1'b0; s.e0[75:72] = 4'd7;
    s.e0[38] = 1'b1; s.r0 = 4'd1;
    drive(s);
    s = idle(); s.c1v = 1'b1; s.c1t = 4'd7; s.c1d = 32'h3F80_0000; drive(s);
    s = idle(); s.i0 = 1'b1; drive(s);

    // Both CDBs carry the tag both operands wait on; CDB0 must win.
    s = idle(); s.d1 = 1'b1; s.e1 = rand_entry(); s.e1[5] = 1'b0; s.e1[38] = 1'b0;
    s.e1[75:72] = 4'd7; s.e1[84:81] = 4'd7; s.r1 = 4'd6;
    drive(s);
    s = idle(); s.c0v = 1'b1; s.c0t = 4'd7; s.c0d = 32'hAAAA_0001;
    s.c1v = 1'b1; s.c1t = 4'd7; s.c1d = 32'hBBBB_0002;
    drive(s);
    s = idle(); s.i0 = 1'b1; s.i1 = 1'b1; drive(s);

    // Issue and dispatch in the same cycle with no free slot, then reuse the freed slot.
    s = idle(); s.d0 = 1'b1; s.e0 = rand_entry(); s.r0 = 4'd8;
    s.d1 = 1'b1; s.e1 = rand_entry(); s.r1 = 4'd9;
    drive(s);
    s = idle(); s.i0 = 1'b1; s.d0 = 1'b1; s.e0 = rand_entry(); s.r0 = 4'd10; drive(s);
    s = idle(); s.d0 = 1'b1; s.e0 = rand_entry(); s.r0 = 4'd11; drive(s);
    s = idle(); s.i0 = 1'b1; s.i1 = 1'b1; drive(s);

    // Dispatch-cycle broadcast of the operand's tag.
    s = idle(); s.d0 = 1'b1; s.e0 = rand_entry(); s.e0[5] = 1'b0; s.e0[75:72] = 4'd9;
    s.e0[38] = 1'b1; s.r0 = 4'd12; s.c0v = 1'b1; s.c0t = 4'd9; s.c0d = 32'h1234_5678;
    drive(s);
    drive(idle());

    // Random traffic within the dispatch contract, with occasional over-subscription and reset.
    for (int c = 0; c < 600; c++) begin
      s = idle();
      s.rstn = ($urandom_range(0, 59) != 0);
      s.e0 = rand_entry(); s.r0 = 4'($urandom);
      s.e1 = rand_entry(); s.r1 = 4'($urandom);
      f = model_free();
      case (f)
        0: begin s.d0 = 1'($urandom); s.d1 = 1'($urandom); end
        1: case ($urandom_range(0, 2))
             0: s.d0 = 1'b1;
             1: s.d1 = 1'b1;
             default: ;
           endcase
        default: begin s.d0 = 1'($urandom); s.d1 = 1'($urandom); end
      endcase
      s.c0v = 1'($urandom); s.c0t = 4'($urandom_range(0, 5)); s.c0d = $urandom;
      s.c1v = 1'($urandom); s.c1t = 4'($urandom_range(0, 5)); s.c1d = $urandom;
      s.i0 = ($urandom_range(0, 2) == 0);
      s.i1 = ($urandom_range(0, 2) == 0);
      drive(s);
    end
    drive(idle());

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
